keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad (Pmod KYPD style) and is the input-side counterpart of the seven-segment display multiplexer. It drives one active-low column strobe at a time from a free-running dwell counter and samples the active-low rows. It rejects multi-key ghosts, debounces over whole scans, and reports each debounced press as a 4-bit hex code plus a one-cycle valid pulse. Typical consumers are the CPU input port and the display path.

Parameters:
SCAN_BITS, 17, column dwell is 2^SCAN_BITS clk cycles (about 1.31 ms at 100 MHz); legal range is 2 or more.
DEBOUNCE_SCANS, 4, number of consecutive identical full scans needed to accept a press or a release; legal range is 1 or more.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
row  in  4  keypad rows, active-low, externally pulled up
col  out  4  column strobes, active-low, exactly one low at all times
key_code  out  4  hex code of the last accepted key
key_valid  out  1  one-cycle pulse when a press is accepted
key_down  out  1  high while the accepted key is considered held

Behaviour:
- Everything is clocked on the rising edge of clk. rst is synchronous and active-high and has priority over all other logic.
- Reset values:
  - col=4'b1110; dwell counter=0; column index=0.
  - row synchronizer (two flops) = 4'b1111.
  - FSM=IDLE; debounce count=0; candidate=0.
  - key_code=0, key_valid=0, key_down=0.
- Column scan:
  - The SCAN_BITS-bit dwell counter increments every cycle and wraps.
  - The column index advances when the counter wraps, giving col sequence 1110, 1101, 1011, 0111, 1110, ...
  - The synchronized row vector is sampled on the last cycle of each dwell (counter all ones). The 2-cycle synchronizer lag is covered by the dwell of 4 or more cycles.
- Per-scan accumulation:
  - A row bit that is 0 at the sample point marks a hit at (row r, column c).
  - The hit count (saturating at 2) and the last hit position are cleared at column 0 dwell start.
  - The scan result is produced at the column 3 sample point (the scan tick): NONE (0 hits), SINGLE(k) (1 hit), or MULTI (2 or more hits).
- Key map, key_code[row][col] with col0=col[0]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM (evaluated only on the scan tick; holds otherwise):
  - IDLE:
    - SINGLE(k): cand=k, cnt=1, go to PRESS_DB.
    - If DEBOUNCE_SCANS=1, accept immediately instead.
    - Otherwise stay in IDLE.
  - PRESS_DB:
    - SINGLE(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Accept: key_code<=cand, key_valid=1 for exactly one cycle (the cycle after the tick), key_down<=1, go to HELD.
  - HELD:
    - NONE: cnt=1, go to RELEASE_DB. If DEBOUNCE_SCANS=1, go to IDLE and set key_down<=0 instead.
    - Anything else: stay in HELD. No new event; a different key while held is ignored until release.
  - RELEASE_DB:
    - NONE: cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE and set key_down<=0.
    - SINGLE or MULTI: go back to HELD. key_down stays 1 and no pulse is issued.
- key_code holds its value after release until the next accept.
- Press latency: the pulse comes 1 cycle after the DEBOUNCE_SCANS-th qualifying scan tick.
- Reset mid-operation discards any partial scan and debounce progress. A key held through reset must re-qualify from the first complete scan.

Test Plan:
Bench settings: SCAN_BITS=2, DEBOUNCE_SCANS=3, so one scan is 16 cycles. Row model: row[r]=0 when col[c]=0 and key (r,c) is pressed.
1. Reset, no keys -> col=1110 during reset. It then rotates 1101, 1011, 0111 at 4-cycle intervals; key_valid=0, key_down=0, key_code=0 throughout 10 scans.
2. Press '5' (r1,c1) steadily from reset release -> exactly one key_valid pulse, 1 cycle after the 3rd scan tick; key_code=4'h5, key_down=1; no further pulses over 10 held scans.
3. Bounce '5' pressed/released on alternate scans for 6 scans -> no key_valid; key_down stays 0.
4. Press '1' and '2' together for 4 scans -> no pulse. Then release '1' -> pulse with key_code=4'h2 after 3 more scans.
5. Hold 'D' (r3,c3) until accepted, release, re-press for 1 scan on the 2nd release scan, then release -> key_down stays 1 through the glitch and falls 3 clean scans later; only one pulse in total.
6. Assert rst for 1 cycle while in PRESS_DB (2 scans into pressing '9') with the key still held -> outputs cleared and col=1110. The pulse with key_code=4'h9 arrives only after 3 further complete scans.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time. Each column
// is strobed low for 2^SCAN_BITS clocks. The synchronized rows are sampled
// on the last cycle of each dwell. A complete four-column scan is
// classified as no key, one key or several keys. Multi-key scans are
// treated as ghosts. A press or release is accepted only after
// DEBOUNCE_SCANS identical consecutive scans.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high, highest priority
//   row[3:0]   keypad rows, active-low (externally pulled up)
//   col[3:0]   column strobes, active-low, exactly one low at a time
//   key_code   hex code of the most recently accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_down   high while the accepted key is considered held
//
// FSM states:
//   state      | meaning
//   IDLE       | no key held, waiting for a single-key scan
//   PRESS_DB   | same single key seen on cnt consecutive scans
//   HELD       | key accepted, waiting for an empty scan
//   RELEASE_DB | empty scans seen cnt times in a row after a hold

module keypad_scanner #(
    parameter int SCAN_BITS      = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [SCAN_BITS-1:0] dwell_cnt;
    logic [1:0]           col_idx;
    logic                 dwell_last;
    logic                 dwell_first;

    logic [3:0] row_meta;
    logic [3:0] row_sync;

    logic [1:0] col_hits;
    logic [1:0] col_hit_row;
    logic [1:0] hit_cnt;
    logic [1:0] hit_row;
    logic [1:0] hit_col;
    logic [2:0] hit_sum;
    logic [1:0] scan_hits;
    logic [1:0] scan_row;
    logic [1:0] scan_col;
    logic [3:0] scan_code;
    logic       scan_tick;
    logic       scan_none;
    logic       scan_single;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]       cand, cand_next;
    logic [3:0]       key_code_next;
    logic             key_valid_next;
    logic             key_down_next;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Column scan
    assign dwell_last  = &dwell_cnt;
    assign dwell_first = (dwell_cnt == '0);
    assign col         = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
        end else begin
            dwell_cnt <= dwell_cnt + SCAN_BITS'(1);
            if (dwell_last) begin
                col_idx <= col_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Hits in the current column, saturating at 2
    always_comb begin
        col_hits    = 2'd0;
        col_hit_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_hit_row = r[1:0];
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
    end

    // Scan result includes the column being sampled right now, so the
    // tick at column 3 sees the complete scan without an extra cycle.
    assign hit_sum     = {1'b0, hit_cnt} + {1'b0, col_hits};
    assign scan_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    assign scan_row    = (col_hits != 2'd0) ? col_hit_row : hit_row;
    assign scan_col    = (col_hits != 2'd0) ? col_idx     : hit_col;
    assign scan_code   = key_map(scan_row, scan_col);
    assign scan_tick   = dwell_last && (col_idx == 2'd3);
    assign scan_none   = (scan_hits == 2'd0);
    assign scan_single = (scan_hits == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= 2'd0;
            hit_row <= 2'd0;
            hit_col <= 2'd0;
        end else if (dwell_first && col_idx == 2'd0) begin
            hit_cnt <= 2'd0;
            hit_row <= 2'd0;
            hit_col <= 2'd0;
        end else if (dwell_last) begin
            hit_cnt <= scan_hits;
            if (col_hits != 2'd0) begin
                hit_row <= col_hit_row;
                hit_col <= col_idx;
            end
        end
    end

    // Debounce FSM
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cand      <= cand_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_down  <= key_down_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        cand_next      = cand;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_down_next  = key_down;
        if (scan_tick) begin
            case (state)
                IDLE: begin
                    if (scan_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_next  = scan_code;
                            key_valid_next = 1'b1;
                            key_down_next  = 1'b1;
                            state_next     = HELD;
                        end else begin
                            cand_next  = scan_code;
                            cnt_next   = CNT_W'(1);
                            state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (scan_single) begin
                        if (scan_code == cand) begin
                            if (cnt_inc == CNT_DONE) begin
                                key_code_next  = cand;
                                key_valid_next = 1'b1;
                                key_down_next  = 1'b1;
                                state_next     = HELD;
                            end else begin
                                cnt_next = cnt_inc;
                            end
                        end else begin
                            cand_next = scan_code;
                            cnt_next  = CNT_W'(1);
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (scan_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_down_next = 1'b0;
                            state_next    = IDLE;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = RELEASE_DB;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (scan_none) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_down_next = 1'b0;
                            state_next    = IDLE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
